// File: rtl/player_direction_ctrl_if.sv
// Per-player direction request/response bundle for player_direction_ctrl.
// Lane p of each vector belongs to player p (2 bits per player for directions).
interface player_direction_ctrl_if #(
  parameter int NUM_PLAYERS = 2
);
  logic [2*NUM_PLAYERS-1:0] dir_req;
  logic [NUM_PLAYERS-1:0]   dir_req_valid;
  logic [2*NUM_PLAYERS-1:0] dir_cur;
  logic [NUM_PLAYERS-1:0]   turned;
  logic [NUM_PLAYERS-1:0]   rejected;
  logic [NUM_PLAYERS-1:0]   q_full;

  modport master (
    output dir_req, dir_req_valid,
    input  dir_cur, turned, rejected, q_full
  );

  modport slave (
    input  dir_req, dir_req_valid,
    output dir_cur, turned, rejected, q_full
  );
endinterface

// File: rtl/player_direction_ctrl.sv
// Per-player turn queue: buffers legal direction requests and applies one per tick.
// Requests equal to or opposite the most recent direction (queued or current) are refused.
module player_direction_ctrl #(
  parameter int                       NUM_PLAYERS = 2,
  parameter int                       QDEPTH      = 2,
  parameter logic [2*NUM_PLAYERS-1:0] INIT_DIRS   = {2'b00, 2'b11}
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 tick,
  input  logic                 freeze,
  input  logic                 clear,
  player_direction_ctrl_if.slave bus
);

  localparam logic [2:0] DEPTH = 3'(QDEPTH);

  logic active;
  assign active = !freeze && !clear;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [1:0] q   [QDEPTH];
    logic [1:0] q_n [QDEPTH];
    logic [2:0] cnt, cnt_n;
    logic [1:0] dir, req, tref;
    logic       req_hit, bad, pop, push;
    logic       turned_r, rejected_r;

    assign req = bus.dir_req[2*p +: 2];

    always_comb begin
      // Reference direction uses pre-edge state, so a head being popped still counts.
      tref = dir;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (3'(i) + 3'd1 == cnt) tref = q[i];
      end
      req_hit = active && bus.dir_req_valid[p];
      bad     = (req == tref) || (req == ~tref);
      pop     = active && tick && (cnt != '0);
      push    = req_hit && !bad && ((cnt < DEPTH) || pop);

      cnt_n = cnt;
      for (int unsigned i = 0; i < QDEPTH; i++) q_n[i] = q[i];
      if (pop) begin
        for (int unsigned i = 0; i + 1 < QDEPTH; i++) q_n[i] = q[i+1];
        cnt_n = cnt - 3'd1;
      end
      if (push) begin
        for (int unsigned i = 0; i < QDEPTH; i++) begin
          if (3'(i) == cnt_n) q_n[i] = req;
        end
        cnt_n = cnt_n + 3'd1;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt        <= '0;
        dir        <= INIT_DIRS[2*p +: 2];
        turned_r   <= 1'b0;
        rejected_r <= 1'b0;
        for (int unsigned i = 0; i < QDEPTH; i++) q[i] <= '0;
      end else if (clear) begin
        cnt        <= '0;
        dir        <= INIT_DIRS[2*p +: 2];
        turned_r   <= 1'b0;
        rejected_r <= 1'b0;
      end else begin
        cnt        <= cnt_n;
        for (int unsigned i = 0; i < QDEPTH; i++) q[i] <= q_n[i];
        // Head is read pre-edge: an entry pushed this cycle can never be popped this cycle.
        if (pop) dir <= q[0];
        turned_r   <= pop;
        rejected_r <= req_hit && !push;
      end
    end

    assign bus.dir_cur[2*p +: 2] = dir;
    assign bus.turned[p]         = turned_r;
    assign bus.rejected[p]       = rejected_r;
    assign bus.q_full[p]         = (cnt == DEPTH);
  end

endmodule

// File: tb/tb_player_direction_ctrl.sv
// Bench for player_direction_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_player_direction_ctrl;
  localparam int NP = 2;
  localparam int QD = 2;
  localparam logic [2*NP-1:0] INIT = {2'b00, 2'b11};

  logic clk = 1'b0;
  logic resetn;
  logic tick, freeze, clear;
  int   nt = 0;
  int   nf = 0;

  player_direction_ctrl_if #(.NUM_PLAYERS(NP)) bus ();

  player_direction_ctrl #(
    .NUM_PLAYERS(NP),
    .QDEPTH     (QD),
    .INIT_DIRS  (INIT)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .tick  (tick),
    .freeze(freeze),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model: one plain queue per player plus its current direction.
  logic [1:0]    mcur [NP];
  logic [1:0]    mq   [NP][$];
  logic [NP-1:0] mturn, mrej;

  task automatic model_reset();
    logic [2*NP-1:0] iv;
    iv = INIT;
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      mcur[p] = iv[2*p +: 2];
    end
    mturn = '0;
    mrej  = '0;
  endtask

  task automatic model_step(input logic t, input logic f, input logic c,
                            input logic [NP-1:0] v, input logic [2*NP-1:0] r);
    logic [2*NP-1:0] iv;
    iv = INIT;
    for (int p = 0; p < NP; p++) begin
      logic [1:0] d, tr, old;
      logic       acc, pp;
      mturn[p] = 1'b0;
      mrej[p]  = 1'b0;
      if (c) begin
        mq[p].delete();
        mcur[p] = iv[2*p +: 2];
      end else if (!f) begin
        d   = r[2*p +: 2];
        tr  = (mq[p].size() > 0) ? mq[p][$] : mcur[p];
        pp  = t && (mq[p].size() > 0);
        acc = 1'b0;
        if (v[p]) begin
          if (d == tr || d == ~tr)            mrej[p] = 1'b1;
          else if (mq[p].size() < QD || pp)   acc = 1'b1;
          else                                mrej[p] = 1'b1;
        end
        old = mcur[p];
        if (pp)  mcur[p] = mq[p].pop_front();
        if (acc) mq[p].push_back(d);
        mturn[p] = (mcur[p] != old);
      end
    end
  endtask

  function automatic logic [2*NP-1:0] exp_dir();
    logic [2*NP-1:0] e;
    for (int p = 0; p < NP; p++) e[2*p +: 2] = mcur[p];
    return e;
  endfunction

  function automatic logic [NP-1:0] exp_full();
    logic [NP-1:0] e;
    for (int p = 0; p < NP; p++) e[p] = (mq[p].size() == QD);
    return e;
  endfunction

  task automatic cycle(input logic t, input logic f, input logic c,
                       input logic [NP-1:0] v, input logic [2*NP-1:0] r);
    tick = t; freeze = f; clear = c;
    bus.dir_req_valid = v;
    bus.dir_req = r;
    @(posedge clk);
    model_step(t, f, c, v, r);
    #1;
    tick = 1'b0; freeze = 1'b0; clear = 1'b0;
    bus.dir_req_valid = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; tick = 1'b0; freeze = 1'b0; clear = 1'b0;
    bus.dir_req_valid = '0; bus.dir_req = '0;
    model_reset();
    #12;
    nt++; if (bus.dir_cur !== 4'b0011) begin nf++; $display("FAIL reset_dir: got %b want 0011", bus.dir_cur); end
    nt++; if (bus.turned !== 2'b00) begin nf++; $display("FAIL reset_turned: got %b want 00", bus.turned); end
    nt++; if (bus.rejected !== 2'b00) begin nf++; $display("FAIL reset_rejected: got %b want 00", bus.rejected); end
    nt++; if (bus.q_full !== 2'b00) begin nf++; $display("FAIL reset_qfull: got %b want 00", bus.q_full); end
    @(negedge clk) resetn = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
    nt++; if (bus.dir_cur !== 4'b0011) begin nf++; $display("FAIL idle_tick_dir: got %b want 0011", bus.dir_cur); end
    nt++; if (bus.turned !== 2'b00) begin nf++; $display("FAIL idle_tick_turned: got %b want 00", bus.turned); end
  endtask

  task automatic test_reject_reverse();
    cycle(1'b0, 1'b0, 1'b0, 2'b01, {2'b00, 2'b00});
    nt++; if (bus.rejected !== 2'b01) begin nf++; $display("FAIL reverse_rejected: got %b want 01", bus.rejected); end
    nt++; if (bus.q_full !== 2'b00) begin nf++; $display("FAIL reverse_qfull: got %b want 00", bus.q_full); end
    cycle(1'b0, 1'b0, 1'b0, 2'b01, {2'b00, 2'b10});
    nt++; if (bus.rejected !== 2'b00) begin nf++; $display("FAIL left_accept: got %b want 00", bus.rejected); end
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
    nt++; if (bus.dir_cur[1:0] !== 2'b10) begin nf++; $display("FAIL left_turn_dir: got %b want 10", bus.dir_cur[1:0]); end
    nt++; if (bus.turned !== 2'b01) begin nf++; $display("FAIL left_turned: got %b want 01", bus.turned); end
  endtask

  task automatic test_queue_full();
    cycle(1'b0, 1'b0, 1'b0, 2'b10, {2'b01, 2'b00});
    nt++; if (bus.rejected !== 2'b00) begin nf++; $display("FAIL full_req1: got %b want 00", bus.rejected); end
    cycle(1'b0, 1'b0, 1'b0, 2'b10, {2'b11, 2'b00});
    nt++; if (bus.q_full !== 2'b10) begin nf++; $display("FAIL full_flag: got %b want 10", bus.q_full); end
    cycle(1'b0, 1'b0, 1'b0, 2'b10, {2'b10, 2'b00});
    nt++; if (bus.rejected !== 2'b10) begin nf++; $display("FAIL full_reject: got %b want 10", bus.rejected); end
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
    nt++; if (bus.dir_cur[3:2] !== 2'b01) begin nf++; $display("FAIL full_pop1: got %b want 01", bus.dir_cur[3:2]); end
    nt++; if (bus.turned !== 2'b10) begin nf++; $display("FAIL full_pop1_turned: got %b want 10", bus.turned); end
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
    nt++; if (bus.dir_cur[3:2] !== 2'b11) begin nf++; $display("FAIL full_pop2: got %b want 11", bus.dir_cur[3:2]); end
    nt++; if (bus.q_full !== 2'b00) begin nf++; $display("FAIL full_drained: got %b want 00", bus.q_full); end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b0, 1'b1, 2'b00, 4'b0000);
    nt++; if (bus.dir_cur !== 4'b0011) begin nf++; $display("FAIL b2b_clear: got %b want 0011", bus.dir_cur); end
    cycle(1'b0, 1'b0, 1'b0, 2'b10, {2'b01, 2'b00});
    cycle(1'b1, 1'b0, 1'b0, 2'b10, {2'b10, 2'b00});
    nt++; if (bus.dir_cur[3:2] !== 2'b01) begin nf++; $display("FAIL b2b_dir: got %b want 01", bus.dir_cur[3:2]); end
    nt++; if (bus.turned !== 2'b10) begin nf++; $display("FAIL b2b_turned: got %b want 10", bus.turned); end
    nt++; if (bus.rejected !== 2'b10) begin nf++; $display("FAIL b2b_rejected: got %b want 10", bus.rejected); end
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
    nt++; if (bus.turned !== 2'b00) begin nf++; $display("FAIL b2b_empty: got %b want 00", bus.turned); end
  endtask

  task automatic test_freeze_clear();
    cycle(1'b0, 1'b0, 1'b0, 2'b11, {2'b11, 2'b01});
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 2'b11, {2'b00, 2'b10});
      nt++; if (bus.dir_cur !== 4'b0111) begin nf++; $display("FAIL freeze_dir: got %b want 0111", bus.dir_cur); end
      nt++; if ((bus.turned | bus.rejected) !== 2'b00) begin nf++; $display("FAIL freeze_pulse: got t=%b r=%b want 00", bus.turned, bus.rejected); end
    end
    cycle(1'b1, 1'b1, 1'b1, 2'b11, {2'b01, 2'b01});
    nt++; if (bus.dir_cur !== 4'b0011) begin nf++; $display("FAIL clear_dir: got %b want 0011", bus.dir_cur); end
    nt++; if ((bus.turned | bus.rejected | bus.q_full) !== 2'b00) begin nf++; $display("FAIL clear_flags: got t=%b r=%b f=%b want 00", bus.turned, bus.rejected, bus.q_full); end
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
    nt++; if (bus.turned !== 2'b00) begin nf++; $display("FAIL clear_empty: got %b want 00", bus.turned); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b0, 1'b0, 2'b01, {2'b00, 2'b01});
    cycle(1'b0, 1'b0, 1'b0, 2'b01, {2'b00, 2'b00});
    nt++; if (bus.q_full !== 2'b01) begin nf++; $display("FAIL mid_full: got %b want 01", bus.q_full); end
    #3 resetn = 1'b0;
    model_reset();
    #1;
    nt++; if (bus.dir_cur !== 4'b0011) begin nf++; $display("FAIL mid_reset_dir: got %b want 0011", bus.dir_cur); end
    nt++; if (bus.q_full !== 2'b00) begin nf++; $display("FAIL mid_reset_qfull: got %b want 00", bus.q_full); end
    @(negedge clk) resetn = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 4'b0000);
    nt++; if (bus.turned !== 2'b00) begin nf++; $display("FAIL mid_first_tick: got %b want 00", bus.turned); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom % 3) == 0, ($urandom % 10) == 0, ($urandom % 40) == 0,
            NP'($urandom), (2*NP)'($urandom));
      nt++; if (bus.dir_cur !== exp_dir()) begin nf++; $display("FAIL rand_dir[%0d]: got %b want %b", k, bus.dir_cur, exp_dir()); end
      nt++; if (bus.turned !== mturn) begin nf++; $display("FAIL rand_turned[%0d]: got %b want %b", k, bus.turned, mturn); end
      nt++; if (bus.rejected !== mrej) begin nf++; $display("FAIL rand_rejected[%0d]: got %b want %b", k, bus.rejected, mrej); end
      nt++; if (bus.q_full !== exp_full()) begin nf++; $display("FAIL rand_qfull[%0d]: got %b want %b", k, bus.q_full, exp_full()); end
    end
  endtask

  initial begin
    test_reset();
    test_reject_reverse();
    test_queue_full();
    test_back_to_back();
    test_freeze_clear();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
